// File: rtl/chirp_frame_gen_if.sv
// Control and sample-stream signals of the chirp/frame timing generator.
// master: the controlling side that drives enable and ADC samples.
// slave: the generator itself.
interface chirp_frame_gen_if;
    logic        i_enable;
    logic        i_adc_tvalid;
    logic [15:0] i_adc_tdata;
    logic        o_cpib;
    logic        o_cpie;
    logic        o_pri;
    logic        o_smp_gate;
    logic        o_tvalid;
    logic [15:0] o_tdata;
    logic        o_busy;
    logic [15:0] o_frame_cnt;
    logic        o_smp_miss;

    modport master (
        output i_enable, i_adc_tvalid, i_adc_tdata,
        input  o_cpib, o_cpie, o_pri, o_smp_gate, o_tvalid, o_tdata,
        input  o_busy, o_frame_cnt, o_smp_miss
    );

    modport slave (
        input  i_enable, i_adc_tvalid, i_adc_tdata,
        output o_cpib, o_cpie, o_pri, o_smp_gate, o_tvalid, o_tdata,
        output o_busy, o_frame_cnt, o_smp_miss
    );
endinterface

// File: rtl/chirp_frame_gen.sv
// Chirp/frame timing generator: produces CPI begin/end strobes, PRI pulses and a
// per-PRI sampling window, and gates the ADC stream through that window.
// Every output is a flop; the output flops are loaded from the *next* counter
// values so that the outputs of a cycle always describe that cycle's position.
module chirp_frame_gen #(
    parameter int unsigned CHIRP_NUM = 32,
    parameter int unsigned PRI_LEN   = 1000,
    parameter int unsigned PULSE_W   = 4,
    parameter int unsigned SMP_START = 100,
    parameter int unsigned SMP_NUM   = 512
) (
    input logic              clk,
    input logic              rst,
    chirp_frame_gen_if.slave bus
);
    localparam int unsigned POS_W   = $clog2(PRI_LEN);
    localparam int unsigned CHIRP_W = (CHIRP_NUM > 1) ? $clog2(CHIRP_NUM) : 1;
    localparam int unsigned SMP_END = SMP_START + SMP_NUM;

    localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(PRI_LEN - 1);
    localparam logic [CHIRP_W-1:0] CHIRP_LAST = CHIRP_W'(CHIRP_NUM - 1);

    typedef enum logic {StIdle, StRun} state_t;

    state_t             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [CHIRP_W-1:0] chirp_q, chirp_d;
    logic [31:0]        pos_ext;
    logic               frame_last;
    logic               run_d;

    logic cpib_d, cpie_d, pri_d, gate_d, take_d, miss_set, miss_d;

    logic        cpib_q, cpie_q, pri_q, gate_q, tvalid_q, busy_q, miss_q;
    logic [15:0] tdata_q;
    logic [15:0] frame_cnt_q;

    // Next-state and counter advance; a frame only ends at its last cycle.
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        chirp_d    = chirp_q;
        frame_last = (pos_q == POS_LAST) && (chirp_q == CHIRP_LAST);
        case (state_q)
            StIdle: begin
                pos_d   = '0;
                chirp_d = '0;
                if (bus.i_enable) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (frame_last) begin
                    pos_d   = '0;
                    chirp_d = '0;
                    state_d = bus.i_enable ? StRun : StIdle;
                end else if (pos_q == POS_LAST) begin
                    pos_d   = '0;
                    chirp_d = chirp_q + CHIRP_W'(1);
                end else begin
                    pos_d = pos_q + POS_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                pos_d   = '0;
                chirp_d = '0;
            end
        endcase
    end

    // Output decode for the upcoming cycle, including the sample-gate path.
    always_comb begin
        run_d    = (state_d == StRun);
        pos_ext  = 32'(pos_d);
        cpib_d   = run_d && (pos_d == '0) && (chirp_d == '0);
        cpie_d   = run_d && (pos_d == POS_LAST) && (chirp_d == CHIRP_LAST);
        pri_d    = run_d && (pos_ext < PULSE_W);
        gate_d   = run_d && (pos_ext >= SMP_START) && (pos_ext < SMP_END);
        take_d   = gate_d && bus.i_adc_tvalid;
        miss_set = gate_d && !bus.i_adc_tvalid;
        // A miss in the very first gated cycle of a frame must survive the clear.
        miss_d   = cpib_d ? miss_set : (miss_q || miss_set);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            pos_q       <= '0;
            chirp_q     <= '0;
            cpib_q      <= 1'b0;
            cpie_q      <= 1'b0;
            pri_q       <= 1'b0;
            gate_q      <= 1'b0;
            tvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            miss_q      <= 1'b0;
            tdata_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            chirp_q  <= chirp_d;
            cpib_q   <= cpib_d;
            cpie_q   <= cpie_d;
            pri_q    <= pri_d;
            gate_q   <= gate_d;
            tvalid_q <= take_d;
            busy_q   <= run_d;
            miss_q   <= miss_d;
            if (take_d) begin
                tdata_q <= bus.i_adc_tdata;
            end
            // Count moves together with the end-of-frame strobe.
            if (cpie_d) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign bus.o_cpib      = cpib_q;
    assign bus.o_cpie      = cpie_q;
    assign bus.o_pri       = pri_q;
    assign bus.o_smp_gate  = gate_q;
    assign bus.o_tvalid    = tvalid_q;
    assign bus.o_tdata     = tdata_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_frame_cnt = frame_cnt_q;
    assign bus.o_smp_miss  = miss_q;
endmodule

// File: tb/tb_chirp_frame_gen.sv
// Directed bench for chirp_frame_gen with a small frame geometry:
// 3 chirps x 20 cycles, 2-cycle PRI pulse, sample window at offsets 4..11.
module tb_chirp_frame_gen;
    localparam int CHIRP_NUM = 3;
    localparam int PRI_LEN   = 20;
    localparam int PULSE_W   = 2;
    localparam int SMP_START = 4;
    localparam int SMP_NUM   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    chirp_frame_gen_if bus ();

    chirp_frame_gen #(
        .CHIRP_NUM (CHIRP_NUM),
        .PRI_LEN   (PRI_LEN),
        .PULSE_W   (PULSE_W),
        .SMP_START (SMP_START),
        .SMP_NUM   (SMP_NUM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // One record: inputs applied during cycle t, outputs expected in cycle t.
    typedef struct {
        int          scen;
        int          t;
        logic        en;
        logic        adc_v;
        logic        cpib;
        logic        cpie;
        logic        pri;
        logic        gate;
        logic        tvalid;
        logic        busy;
        logic        miss;
        logic [15:0] fc;
    } vec_t;

    vec_t        vecs[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_hold = '0;

    function automatic logic [15:0] ramp(input int t);
        return 16'(4096 + t);
    endfunction

    task automatic chk(input string name, input int t, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%0h want=%0h", name, t, got, exp);
        end
    endtask

    task automatic add(input int scen, input int t, input logic en, input logic adc_v,
                       input logic cpib, input logic cpie, input logic pri, input logic gate,
                       input logic tvalid, input logic busy, input logic miss,
                       input logic [15:0] fc);
        vec_t v;
        v.scen = scen;  v.t = t;       v.en = en;         v.adc_v = adc_v;
        v.cpib = cpib;  v.cpie = cpie; v.pri = pri;       v.gate = gate;
        v.tvalid = tvalid; v.busy = busy; v.miss = miss;  v.fc = fc;
        vecs.push_back(v);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   0, 32'(bus.o_busy), 0);
        chk({tag, "_cpib"},   0, 32'(bus.o_cpib), 0);
        chk({tag, "_cpie"},   0, 32'(bus.o_cpie), 0);
        chk({tag, "_pri"},    0, 32'(bus.o_pri), 0);
        chk({tag, "_gate"},   0, 32'(bus.o_smp_gate), 0);
        chk({tag, "_tvalid"}, 0, 32'(bus.o_tvalid), 0);
        chk({tag, "_tdata"},  0, 32'(bus.o_tdata), 0);
        chk({tag, "_fc"},     0, 32'(bus.o_frame_cnt), 0);
        chk({tag, "_miss"},   0, 32'(bus.o_smp_miss), 0);
    endtask

    // Start a frame (enable high one cycle before t=0) and run ncyc cycles.
    // Every cycle is checked against the timing model; table rows add strobes/counts.
    task automatic run_scen(input int scen, input int ncyc, input int busy_end,
                            output int tv_cnt);
        logic en_cur;
        logic prev_v;
        logic e_busy, e_pri, e_gate, e_tv;
        int   idx;
        int   ph;
        tv_cnt = 0;
        @(posedge clk);
        #1;
        en_cur = 1'b1;
        prev_v = 1'b1;
        bus.i_enable     = 1'b1;
        bus.i_adc_tvalid = 1'b1;
        bus.i_adc_tdata  = ramp(-1);
        for (int t = 0; t < ncyc; t++) begin
            @(posedge clk);
            #1;
            idx = -1;
            foreach (vecs[i]) begin
                if (vecs[i].scen == scen && vecs[i].t == t) idx = i;
            end
            bus.i_adc_tvalid = 1'b1;
            if (idx >= 0) begin
                en_cur           = vecs[idx].en;
                bus.i_adc_tvalid = vecs[idx].adc_v;
            end
            bus.i_enable    = en_cur;
            bus.i_adc_tdata = ramp(t);
            @(negedge clk);
            ph     = t % PRI_LEN;
            e_busy = (t < busy_end);
            e_pri  = e_busy && (ph < PULSE_W);
            e_gate = e_busy && (ph >= SMP_START) && (ph < SMP_START + SMP_NUM);
            e_tv   = e_gate && prev_v;
            if (e_tv) exp_hold = ramp(t - 1);
            chk("busy",   t, 32'(bus.o_busy), 32'(e_busy));
            chk("pri",    t, 32'(bus.o_pri), 32'(e_pri));
            chk("gate",   t, 32'(bus.o_smp_gate), 32'(e_gate));
            chk("tvalid", t, 32'(bus.o_tvalid), 32'(e_tv));
            chk("tdata",  t, 32'(bus.o_tdata), 32'(exp_hold));
            if (bus.o_tvalid) tv_cnt++;
            if (idx >= 0) begin
                chk("vec_cpib",   t, 32'(bus.o_cpib), 32'(vecs[idx].cpib));
                chk("vec_cpie",   t, 32'(bus.o_cpie), 32'(vecs[idx].cpie));
                chk("vec_pri",    t, 32'(bus.o_pri), 32'(vecs[idx].pri));
                chk("vec_gate",   t, 32'(bus.o_smp_gate), 32'(vecs[idx].gate));
                chk("vec_tvalid", t, 32'(bus.o_tvalid), 32'(vecs[idx].tvalid));
                chk("vec_busy",   t, 32'(bus.o_busy), 32'(vecs[idx].busy));
                chk("vec_miss",   t, 32'(bus.o_smp_miss), 32'(vecs[idx].miss));
                chk("vec_fc",     t, 32'(bus.o_frame_cnt), 32'(vecs[idx].fc));
            end
            prev_v = bus.i_adc_tvalid;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=0 got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tv;
        int act;

        //  scen t   en adc cpib cpie pri gate tv busy miss fc
        // Scenario 3: partial frame, then reset at t=30.
        add(3,   0,  0, 1,  1,   0,   1,  0,   0, 1,   0,   16'd0);
        add(3,  29,  0, 1,  0,   0,   0,  1,   1, 1,   0,   16'd0);
        // Scenario 1: single frame, enable pulsed, ADC valid dropped at t=5.
        add(1,   0,  0, 1,  1,   0,   1,  0,   0, 1,   0,   16'd0);
        add(1,   1,  0, 1,  0,   0,   1,  0,   0, 1,   0,   16'd0);
        add(1,   2,  0, 1,  0,   0,   0,  0,   0, 1,   0,   16'd0);
        add(1,   4,  0, 1,  0,   0,   0,  1,   1, 1,   0,   16'd0);
        add(1,   5,  0, 0,  0,   0,   0,  1,   1, 1,   0,   16'd0);
        add(1,   6,  0, 1,  0,   0,   0,  1,   0, 1,   1,   16'd0);
        add(1,   7,  0, 1,  0,   0,   0,  1,   1, 1,   1,   16'd0);
        add(1,  11,  0, 1,  0,   0,   0,  1,   1, 1,   1,   16'd0);
        add(1,  12,  0, 1,  0,   0,   0,  0,   0, 1,   1,   16'd0);
        add(1,  20,  0, 1,  0,   0,   1,  0,   0, 1,   1,   16'd0);
        add(1,  21,  0, 1,  0,   0,   1,  0,   0, 1,   1,   16'd0);
        add(1,  22,  0, 1,  0,   0,   0,  0,   0, 1,   1,   16'd0);
        add(1,  24,  0, 1,  0,   0,   0,  1,   1, 1,   1,   16'd0);
        add(1,  31,  0, 1,  0,   0,   0,  1,   1, 1,   1,   16'd0);
        add(1,  40,  0, 1,  0,   0,   1,  0,   0, 1,   1,   16'd0);
        add(1,  41,  0, 1,  0,   0,   1,  0,   0, 1,   1,   16'd0);
        add(1,  44,  0, 1,  0,   0,   0,  1,   1, 1,   1,   16'd0);
        add(1,  51,  0, 1,  0,   0,   0,  1,   1, 1,   1,   16'd0);
        add(1,  58,  0, 1,  0,   0,   0,  0,   0, 1,   1,   16'd0);
        add(1,  59,  0, 1,  0,   1,   0,  0,   0, 1,   1,   16'd1);
        add(1,  60,  0, 1,  0,   0,   0,  0,   0, 0,   1,   16'd1);
        add(1,  61,  0, 1,  0,   0,   0,  0,   0, 0,   1,   16'd1);
        // Scenario 2: enable held (back-to-back), dropped mid third frame.
        add(2,   0,  1, 1,  1,   0,   1,  0,   0, 1,   0,   16'd1);
        add(2,  59,  1, 1,  0,   1,   0,  0,   0, 1,   0,   16'd2);
        add(2,  60,  1, 1,  1,   0,   1,  0,   0, 1,   0,   16'd2);
        add(2, 119,  1, 1,  0,   1,   0,  0,   0, 1,   0,   16'd3);
        add(2, 120,  1, 1,  1,   0,   1,  0,   0, 1,   0,   16'd3);
        add(2, 130,  0, 1,  0,   0,   0,  1,   1, 1,   0,   16'd3);
        add(2, 179,  0, 1,  0,   1,   0,  0,   0, 1,   0,   16'd4);
        add(2, 180,  0, 1,  0,   0,   0,  0,   0, 0,   0,   16'd4);
        add(2, 181,  0, 1,  0,   0,   0,  0,   0, 0,   0,   16'd4);
        // Scenario 4: frame counter preset to 0xFFFF wraps at the next frame end.
        add(4,   0,  0, 1,  1,   0,   1,  0,   0, 1,   0,   16'hFFFF);
        add(4,  58,  0, 1,  0,   0,   0,  0,   0, 1,   0,   16'hFFFF);
        add(4,  59,  0, 1,  0,   1,   0,  0,   0, 1,   0,   16'h0000);
        add(4,  60,  0, 1,  0,   0,   0,  0,   0, 0,   0,   16'h0000);

        bus.i_enable     = 1'b0;
        bus.i_adc_tvalid = 1'b1;
        bus.i_adc_tdata  = '0;

        // Power-on reset: outputs must clear before any clock edge.
        #1 rst = 1'b1;
        #2 chk_all_zero("por");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset mid-frame at t=30: immediate clear, no frame end, stays idle.
        run_scen(3, 30, 1000, tv);
        chk("scen3_tv_cnt", 29, tv, 14);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_all_zero("rst_t30");
        exp_hold = '0;
        bus.i_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        act = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (bus.o_busy || bus.o_cpie || bus.o_cpib || bus.o_pri || bus.o_smp_gate) act++;
        end
        chk("idle_after_rst", 0, act, 0);
        chk("fc_after_rst", 0, 32'(bus.o_frame_cnt), 0);

        run_scen(1, 62, 60, tv);
        chk("scen1_tv_cnt", 61, tv, 23);

        run_scen(2, 182, 180, tv);
        chk("scen2_tv_cnt", 181, tv, 72);

        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1 release dut.frame_cnt_q;
        @(negedge clk);
        chk("fc_preset", 0, 32'(bus.o_frame_cnt), 32'h0000FFFF);
        run_scen(4, 61, 60, tv);
        chk("scen4_tv_cnt", 60, tv, 24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/chirp_frame_gen.md
CHIRP_FRAME_GEN -- requirements
Module: chirp_frame_gen

Interface
REQ-001 Parameter CHIRP_NUM, default 32: chirps (PRIs) per frame, 2..1024.
REQ-002 Parameter PRI_LEN, default 1000: clk cycles per PRI, 16..65535.
REQ-003 Parameter PULSE_W, default 4: o_pri high width in cycles, 1..PRI_LEN-1.
REQ-004 Parameter SMP_START, default 100: PRI offset of the first gated sample.
REQ-005 Parameter SMP_NUM, default 512: gated samples per PRI; SMP_START+SMP_NUM <= PRI_LEN.
REQ-006 clk  input  1  sole clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 i_enable  input  1  level; high requests frames.
REQ-009 i_adc_tvalid  input  1  ADC sample valid.
REQ-010 i_adc_tdata  input  16  ADC sample.
REQ-011 o_cpib  output  1  frame-begin pulse (CPI begin).
REQ-012 o_cpie  output  1  frame-end pulse (CPI end).
REQ-013 o_pri  output  1  PRI pulse.
REQ-014 o_smp_gate  output  1  sampling window.
REQ-015 o_tvalid  output  1  gated sample valid.
REQ-016 o_tdata  output  16  gated sample.
REQ-017 o_busy  output  1  frame in progress.
REQ-018 o_frame_cnt  output  16  completed-frame count.
REQ-019 o_smp_miss  output  1  sticky: gate open with no ADC sample.

Function
REQ-020 The FSM SHALL have states IDLE and RUN; all outputs SHALL be registered.
REQ-021 IDLE->RUN when i_enable=1 at a clock edge. Frame cycle t=0 is the first cycle with o_busy=1.
REQ-022 Counters: pos 0..PRI_LEN-1 and chirp 0..CHIRP_NUM-1. pos increments every RUN cycle and wraps to 0. chirp increments on a pos wrap.
REQ-023 o_cpib SHALL be 1 for exactly one cycle, at pos=0, chirp=0.
REQ-024 o_pri SHALL be 1 while pos < PULSE_W, in every chirp.
REQ-025 o_smp_gate SHALL be 1 while SMP_START <= pos < SMP_START+SMP_NUM.
REQ-026 o_cpie SHALL be 1 for exactly one cycle, at pos=PRI_LEN-1, chirp=CHIRP_NUM-1. In that same cycle o_frame_cnt SHALL increment, mod 2^16 wrap.
REQ-027 At the o_cpie cycle:
- if i_enable=1, the next cycle SHALL be t=0 of a new frame (back-to-back, no gap, o_busy stays 1);
- otherwise the FSM SHALL go to IDLE and o_busy=0 the next cycle.
REQ-028 Deasserting i_enable mid-frame SHALL NOT truncate the frame; the frame completes per REQ-027.
REQ-029 o_tvalid(t) SHALL = o_smp_gate(t) AND i_adc_tvalid(t-1), with o_tdata(t) = i_adc_tdata(t-1). o_tdata SHALL hold its last value when o_tvalid=0.
REQ-030 o_smp_miss SHALL set when o_smp_gate(t)=1 and i_adc_tvalid(t-1)=0, and clear at each o_cpib.
REQ-031 In IDLE, o_cpib, o_cpie, o_pri, o_smp_gate and o_tvalid SHALL be 0.

Reset
REQ-032 On rst=1, all outputs SHALL immediately go to 0, the FSM to IDLE and the counters to 0, regardless of clk.
REQ-033 Reset mid-frame SHALL abort the frame with no o_cpie and no o_frame_cnt increment.
REQ-034 After rst deasserts, the first frame starts per REQ-021.

Verification
Directed scenarios use CHIRP_NUM=3, PRI_LEN=20, PULSE_W=2, SMP_START=4, SMP_NUM=8, i_adc_tvalid=1 with a ramp on i_adc_tdata unless stated.
REQ-035 Single frame, i_enable pulsed 1 cycle -> o_cpib at t=0; o_pri at t=0-1, 20-21, 40-41; o_smp_gate at t=4-11, 24-31, 44-51; o_cpie at t=59; o_frame_cnt=1; o_busy=0 at t=60.
REQ-036 i_enable held high -> second o_cpib at t=60, no gap; o_frame_cnt=2 after t=119.
REQ-037 i_adc_tvalid=0 during t=5 only -> o_tvalid=0 at t=6 only; o_smp_miss=1 from t=6, cleared at the next o_cpib.
REQ-038 Sample path -> 8 o_tvalid per chirp; o_tdata equals the ramp value from the previous cycle.
REQ-039 rst asserted at t=30 -> all outputs 0 immediately; no o_cpie; o_frame_cnt unchanged; new frame after release with i_enable=1.
REQ-040 o_frame_cnt preset to 0xFFFF by forcing -> wraps to 0x0000 on the next o_cpie.
